// File: rtl/cmos_dvp_tx_if.sv
// Pixel stream into the DVP transmitter: RGB565 data with a valid/ready handshake.
// The master is the pixel source; the slave is the transmitter.
interface cmos_dvp_tx_if;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;

    modport master (output pix_data, output pix_valid, input pix_ready);
    modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/cmos_dvp_tx.sv
// Camera-side DVP transmitter: turns RGB565 pixels (stream or colour bars) into
// OV-style vsync/href/byte output, one byte per rising edge of cmos_clk_i.
module cmos_dvp_tx #(
    parameter int unsigned H_ACTIVE       = 640,
    parameter int unsigned V_ACTIVE       = 480,
    parameter int unsigned H_BLANK        = 144,
    parameter int unsigned VSYNC_LINES    = 3,
    parameter int unsigned V_BP           = 17,
    parameter int unsigned V_FP           = 10,
    parameter logic [15:0] UNDERFLOW_FILL = 16'h0000
) (
    input  logic              cmos_clk_i,
    input  logic              rst_n_i,
    input  logic              enable_i,
    input  logic              pattern_en_i,
    cmos_dvp_tx_if.slave      pix_if,
    output logic              cmos_vsync_o,
    output logic              cmos_href_o,
    output logic [7:0]        cmos_data_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              underflow_o
);

    localparam int unsigned LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned HREF_LEN = 2 * H_ACTIVE;
    localparam int unsigned BAR_W    = H_ACTIVE / 8;
    localparam int unsigned H_W      = $clog2(LINE_LEN + 1);
    localparam int unsigned V_W      = $clog2(VSYNC_LINES + V_BP + V_ACTIVE + V_FP + 1);
    localparam int unsigned B_W      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFP    = 3'd4
    } state_e;

    // Zero-length phases are never entered, so the frame's first/last phases depend on parameters.
    localparam state_e FIRST_ST = (VSYNC_LINES != 0) ? ST_VSYNC : ((V_BP != 0) ? ST_VBP : ST_ACTIVE);
    localparam state_e LAST_ST  = (V_FP != 0) ? ST_VFP : ST_ACTIVE;

    function automatic logic [V_W-1:0] last_line(input state_e s);
        logic [V_W-1:0] r;
        case (s)
            ST_VSYNC:  r = V_W'(VSYNC_LINES - 1);
            ST_VBP:    r = V_W'(V_BP - 1);
            ST_ACTIVE: r = V_W'(V_ACTIVE - 1);
            ST_VFP:    r = V_W'(V_FP - 1);
            default:   r = '0;
        endcase
        return r;
    endfunction

    // ST_IDLE as a result means "end of frame".
    function automatic state_e phase_after(input state_e s);
        state_e r;
        case (s)
            ST_VSYNC:  r = (V_BP != 0) ? ST_VBP : ST_ACTIVE;
            ST_VBP:    r = ST_ACTIVE;
            ST_ACTIVE: r = (V_FP != 0) ? ST_VFP : ST_IDLE;
            ST_VFP:    r = ST_IDLE;
            default:   r = ST_IDLE;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] bar_color(input logic [2:0] bar);
        logic [15:0] c;
        case (bar)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    state_e         state_q, state_d;
    logic [H_W-1:0] h_q, h_d;
    logic [V_W-1:0] v_q, v_d;
    logic           pattern_q, pattern_d;
    logic [2:0]     bar_q, bar_d;
    logic [B_W-1:0] bcnt_q, bcnt_d;
    logic [7:0]     lo_q, lo_d;
    logic           vsync_q, vsync_d;
    logic           href_q, href_d;
    logic [7:0]     data_q, data_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           underflow_q, underflow_d;

    logic           start_s;
    logic           last_h_s;
    logic           last_v_s;
    logic           emit_s;
    logic [15:0]    pix_sel_s;

    // Next raster position: state, pixel-clock counter and line-within-phase counter.
    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        v_d      = v_q;
        start_s  = 1'b0;
        last_h_s = (h_q == H_W'(LINE_LEN - 1));
        last_v_s = (v_q == last_line(state_q));
        if (state_q == ST_IDLE) begin
            h_d = '0;
            v_d = '0;
            if (enable_i) begin
                state_d = FIRST_ST;
                start_s = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (!last_h_s) begin
            h_d = h_q + H_W'(1);
        end else begin
            h_d = '0;
            if (!last_v_s) begin
                v_d = v_q + V_W'(1);
            end else begin
                v_d = '0;
                if (phase_after(state_q) != ST_IDLE) begin
                    state_d = phase_after(state_q);
                end else if (enable_i) begin
                    state_d = FIRST_ST;
                    start_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    // Outputs for the next position; pixels are fetched on the high-byte cycle.
    always_comb begin
        href_d      = (state_d == ST_ACTIVE) && (h_d < H_W'(HREF_LEN));
        emit_s      = href_d && !h_d[0];
        pattern_d   = start_s ? pattern_en_i : pattern_q;
        pix_sel_s   = UNDERFLOW_FILL;
        if (pattern_q) begin
            pix_sel_s = bar_color(bar_q);
        end else if (pix_if.pix_valid) begin
            pix_sel_s = pix_if.pix_data;
        end else begin
            pix_sel_s = UNDERFLOW_FILL;
        end
        bar_d  = bar_q;
        bcnt_d = bcnt_q;
        if (!href_d) begin
            bar_d  = 3'd0;
            bcnt_d = '0;
        end else if (emit_s) begin
            if (bcnt_q == B_W'(BAR_W - 1)) begin
                bcnt_d = '0;
                bar_d  = bar_q + 3'd1;
            end else begin
                bcnt_d = bcnt_q + B_W'(1);
            end
        end else begin
            bar_d  = bar_q;
            bcnt_d = bcnt_q;
        end
        lo_d = emit_s ? pix_sel_s[7:0] : lo_q;
        if (!href_d) begin
            data_d = 8'h00;
        end else if (emit_s) begin
            data_d = pix_sel_s[15:8];
        end else begin
            data_d = lo_q;
        end
        underflow_d = start_s ? 1'b0 : (underflow_q | (emit_s & ~pattern_q & ~pix_if.pix_valid));
        vsync_d     = (state_d == ST_VSYNC);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == LAST_ST) && (v_d == last_line(LAST_ST)) &&
                      (h_d == H_W'(LINE_LEN - 1));
    end

    assign pix_if.pix_ready = emit_s & ~pattern_q;

    // State, counters and registered outputs.
    always_ff @(posedge cmos_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            h_q         <= '0;
            v_q         <= '0;
            pattern_q   <= 1'b0;
            bar_q       <= 3'd0;
            bcnt_q      <= '0;
            lo_q        <= 8'h00;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            data_q      <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            v_q         <= v_d;
            pattern_q   <= pattern_d;
            bar_q       <= bar_d;
            bcnt_q      <= bcnt_d;
            lo_q        <= lo_d;
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            underflow_q <= underflow_d;
        end
    end

    assign cmos_vsync_o = vsync_q;
    assign cmos_href_o  = href_q;
    assign cmos_data_o  = data_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign underflow_o  = underflow_q;

endmodule

// File: tb/tb_cmos_dvp_tx.sv
// Directed + randomized bench for cmos_dvp_tx with small raster parameters and a
// position-based reference model of the frame.
module tb_cmos_dvp_tx;
    localparam int HA = 8, VA = 2, HB = 4, VS = 1, VBP = 1, VFP = 1;
    localparam int LL = 2 * HA + HB;
    localparam int FRAME = LL * (VS + VBP + VA + VFP);
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       pattern_en = 1'b0;
    logic       vsync, href, busy, frame_done, underflow;
    logic [7:0] data;

    cmos_dvp_tx_if pif ();

    cmos_dvp_tx #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
        .VSYNC_LINES(VS), .V_BP(VBP), .V_FP(VFP), .UNDERFLOW_FILL(16'h0000)
    ) dut (
        .cmos_clk_i   (clk),
        .rst_n_i      (rst_n),
        .enable_i     (enable),
        .pattern_en_i (pattern_en),
        .pix_if       (pif.slave),
        .cmos_vsync_o (vsync),
        .cmos_href_o  (href),
        .cmos_data_o  (data),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .underflow_o  (underflow)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    bit          pat_f = 1'b0;
    bit          uf_m = 1'b0;
    bit          rnd_mode = 1'b0;
    int          drop_k = -1;
    int          accepts = 0;
    logic [15:0] offer = 16'h1234;
    logic [15:0] cur_pix = 16'h0000;

    // One raster position: drive for it, check ready, clock, then check the outputs.
    // k is the position inside the frame; k < 0 means the transmitter should be idle.
    task automatic step(input int k);
        int          line, h;
        bit          hr, even_act, hs, exp_ready;
        logic [7:0]  dexp;
        logic [12:0] exp_v, got_v;
        line = (k >= 0) ? k / LL : -1;
        h    = (k >= 0) ? k % LL : 0;
        hr   = (k >= 0) && (line >= VS + VBP) && (line < VS + VBP + VA) && (h < 2 * HA);
        even_act = hr && (h % 2 == 0);
        if (k == 0) begin
            pat_f = pattern_en;
            uf_m  = 1'b0;
        end
        pif.pix_valid = rnd_mode ? ($urandom_range(0, 3) != 0) : (k != drop_k);
        pif.pix_data  = offer;
        exp_ready = even_act && !pat_f;
        tests++;
        assert (pif.pix_ready === exp_ready)
        else begin
            fails++;
            $error("FAIL ready k=%0d observed=%b expected=%b", k, pif.pix_ready, exp_ready);
        end
        if (even_act) begin
            if (pat_f) begin
                cur_pix = BARS[(h / 2) / (HA / 8)];
            end else if (pif.pix_valid) begin
                cur_pix = offer;
            end else begin
                cur_pix = 16'h0000;
                uf_m    = 1'b1;
            end
        end
        hs = pif.pix_ready && pif.pix_valid;
        @(posedge clk);
        if (hs) begin
            accepts++;
            offer = rnd_mode ? 16'($urandom) : offer + 16'd1;
        end
        @(negedge clk);
        if (!hr) dexp = 8'h00;
        else if (h % 2 == 0) dexp = cur_pix[15:8];
        else dexp = cur_pix[7:0];
        exp_v = {(k >= 0) && (line < VS), hr, dexp, k >= 0, k == FRAME - 1, uf_m};
        got_v = {vsync, href, data, busy, frame_done, underflow};
        tests++;
        assert (got_v === exp_v)
        else begin
            fails++;
            $error("FAIL outputs k=%0d observed={vs,href,data,busy,done,uf}=%h expected=%h",
                   k, got_v, exp_v);
        end
    endtask

    task automatic check_accepts(input string tag, input int expected);
        tests++;
        assert (accepts === expected)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, accepts, expected);
        end
    endtask

    initial begin
        pif.pix_valid = 1'b0;
        pif.pix_data  = 16'h0000;
        enable        = 1'b1;
        pattern_en    = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        assert ({vsync, href, data, busy, frame_done, underflow, pif.pix_ready} === 14'h0)
        else begin
            fails++;
            $error("FAIL reset_state observed=%b%b%h%b%b%b%b expected all zero",
                   vsync, href, data, busy, frame_done, underflow, pif.pix_ready);
        end
        rst_n = 1'b1;

        // Frame A: colour bars; pattern_en_i change mid-frame must not take effect until next frame.
        for (int k = 0; k < FRAME; k++) begin
            if (k == 60) pattern_en = 1'b0;
            step(k);
        end

        // Frame B: stream with valid always high, consecutive pixel values.
        accepts = 0;
        offer   = 16'h1234;
        for (int k = 0; k < FRAME; k++) step(k);
        check_accepts("accepts_full", 2 * HA);

        // Frame C: valid dropped for the 3rd pixel of the first active line.
        accepts = 0;
        drop_k  = (VS + VBP) * LL + 4;
        for (int k = 0; k < FRAME; k++) step(k);
        check_accepts("accepts_drop", 2 * HA - 1);
        drop_k = -1;

        // Frame D: random valid and data; enable dropped mid-active, then idle.
        rnd_mode = 1'b1;
        offer    = 16'($urandom);
        for (int k = 0; k < FRAME; k++) begin
            if (k == 50) enable = 1'b0;
            step(k);
        end
        for (int i = 0; i < 30; i++) step(-1);

        // Frame E: restart, then asynchronous reset in the middle of an active line.
        enable = 1'b1;
        for (int k = 0; k <= (VS + VBP) * LL + 5; k++) step(k);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        assert ({vsync, href, data, busy, frame_done, underflow, pif.pix_ready} === 14'h0)
        else begin
            fails++;
            $error("FAIL async_reset observed=%b%b%h%b%b%b%b expected all zero",
                   vsync, href, data, busy, frame_done, underflow, pif.pix_ready);
        end
        @(negedge clk);
        rst_n      = 1'b1;
        uf_m       = 1'b0;
        pattern_en = 1'b1;
        rnd_mode   = 1'b0;

        // Frame F: clean pattern frame after reset, then stop.
        for (int k = 0; k < FRAME; k++) begin
            if (k == FRAME - 1) enable = 1'b0;
            step(k);
        end
        for (int i = 0; i < 5; i++) step(-1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
